ysyx_23060201_ifu_fetch: RTL and testbench
==========================================

Name: ysyx_23060201_ifu_fetch

Overview:
Instruction-fetch stage directly upstream of the execute stage. Owns the architectural PC and issues one instruction-memory read per instruction over a valid/ready request channel. Presents the fetched word and its PC to decode/execute, then waits for the execute stage's dnpc before fetching again. Multi-cycle, non-pipelined: one instruction in flight at a time.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, max cycles in WAIT with no response before error; 8-bit counter; 0 disables the timeout.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous reset, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address (= pc)
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  32  instruction word
imem_rsp_err  input  1  bus error on response
inst_valid  output  1  inst/pc valid to decode
inst_ready  input  1  decode/execute accepts inst
inst  output  32  fetched instruction
pc  output  32  PC of inst
npc_valid  input  1  execute presents next PC
dnpc  input  32  next PC from execute
fetch_err  output  1  sticky error flag
perf_fetch_cnt  output  32  retired-fetch counter (see Optional Feature)
perf_wait_cnt  output  32  memory-wait cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at clk edge): pc<=RESET_PC, inst<=0, state<=REQ, timeout cnt<=0, fetch_err<=0, perf counters<=0. Any outstanding request/response is abandoned. While rst=1: imem_req_valid=0, inst_valid=0.
- States: REQ, WAIT, HOLD, EXEC, ERR.
- REQ: imem_req_valid=1, imem_req_addr=pc. req_ready=1 -> WAIT, timeout cnt<=0. Otherwise stay; addr stable.
- WAIT: imem_req_valid=0. On rsp_valid=1: err=1 -> ERR; else inst<=rsp_data -> HOLD. No response: cnt++. cnt reaching TIMEOUT (TIMEOUT!=0) -> ERR.
- HOLD: inst_valid=1; inst and pc stable. inst_ready=1 -> EXEC.
- EXEC: inst_valid=0. On npc_valid=1: dnpc[1:0]!=0 -> ERR (pc unchanged); else pc<=dnpc -> REQ.
- ERR: fetch_err=1 sticky; req_valid=0, inst_valid=0. Left only by reset.
- Ignored inputs: rsp_valid outside WAIT is dropped. npc_valid outside EXEC is dropped. inst_ready outside HOLD has no effect.
- Latency, zero-wait memory (ready=1, rsp one cycle after acceptance), inst_ready and npc_valid both tied 1: 4 cycles per instruction (REQ, WAIT, HOLD, EXEC).
- fetch_err is registered: asserted the cycle after the ERR transition.
- pc wraps modulo 2^32; no overflow check.

Optional Feature:
Macro YSYX_23060201_IFU_PERF_EN.
- Defined: perf_fetch_cnt increments on each HOLD->EXEC transition. perf_wait_cnt increments on every cycle spent in WAIT. Both 32-bit, wrap to 0, cleared by reset.
- Undefined: both ports are tied to 32'h0 and no counter flops are built.
- The port list is identical in both builds.

Test Plan:
1. Reset, then memory with ready=1 and 1-cycle rsp data 32'h0000_0013; inst_ready=1; npc_valid=1 with dnpc=pc+4 -> addresses 0x80000000, 0x80000004, 0x80000008 on consecutive fetches; one inst_valid pulse every 4 cycles.
2. Back-pressure: req_ready held low 3 cycles, inst_ready held low 5 cycles -> imem_req_addr stable and inst/pc stable throughout; exactly one fetch per instruction.
3. Jump: execute returns dnpc=32'h8000_0100 -> next imem_req_addr=32'h8000_0100. Then dnpc=32'h8000_0102 -> fetch_err=1, no further requests.
4. Bus error: rsp_valid=1 with rsp_err=1 -> ERR; fetch_err=1; inst_valid never asserts. Assert rst -> pc=0x80000000, fetch_err=0, fetching resumes.
5. Timeout with TIMEOUT=4: no response after acceptance -> fetch_err asserts 5 cycles after acceptance. A late rsp_valid is then ignored.
6. Reset mid-WAIT, plus a stray rsp_valid in the first REQ cycle after reset -> response dropped; a fresh request is issued to RESET_PC. With YSYX_23060201_IFU_PERF_EN and 3 fetches at 2 wait cycles each -> perf_fetch_cnt=3, perf_wait_cnt=6.

Source files
------------

// File: rtl/ysyx_23060201_ifu_fetch.sv
// Non-pipelined instruction fetch: REQ -> WAIT -> HOLD -> EXEC, one instruction in flight.
// Optional perf counters are built only when YSYX_23060201_IFU_PERF_EN is defined.
module ysyx_23060201_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        npc_valid,
  input  logic [31:0] dnpc,
  output logic        fetch_err,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_EXEC, S_ERR} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] pc_nxt, inst_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      cnt       <= 8'd0;
      pc        <= RESET_PC;
      inst      <= 32'd0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pc    <= pc_nxt;
      inst  <= inst_nxt;
      // Registered off the state, so it rises one cycle after entering ERR.
      if (state == S_ERR) fetch_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc;
    inst_nxt  = inst;
    case (state)
      S_REQ: begin
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 8'd0;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_nxt = S_ERR;
          end else begin
            inst_nxt  = imem_rsp_data;
            state_nxt = S_HOLD;
          end
        end else if (TO_LIM != 8'd0 && cnt + 8'd1 == TO_LIM) begin
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (inst_ready) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (npc_valid) begin
          if (dnpc[1:0] != 2'b00) begin
            state_nxt = S_ERR;
          end else begin
            pc_nxt    = dnpc;
            state_nxt = S_REQ;
          end
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  assign imem_req_valid = !rst && (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = !rst && (state == S_HOLD);

`ifdef YSYX_23060201_IFU_PERF_EN
  logic [31:0] fetch_q, wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= 32'd0;
      wait_q  <= 32'd0;
    end else begin
      if (state == S_HOLD && inst_ready) fetch_q <= fetch_q + 32'd1;
      if (state == S_WAIT) wait_q <= wait_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_q;
  assign perf_wait_cnt  = wait_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_wait_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_23060201_ifu_fetch.sv
// Scoreboard bench: stimulus pushes expected fetch addresses and instructions, a negedge monitor checks them.
module tb_ysyx_23060201_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, pc;
  logic        npc_valid;
  logic [31:0] dnpc;
  logic        fetch_err;
  logic [31:0] perf_fetch_cnt, perf_wait_cnt;

  always #5 clk = ~clk;

  ysyx_23060201_ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .npc_valid(npc_valid), .dnpc(dnpc), .fetch_err(fetch_err),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_wait_cnt(perf_wait_cnt)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] req_q[$];
  logic [31:0] inst_q[$];
  logic [31:0] ipc_q[$];
  logic [31:0] mdl_pc;
  int unsigned mdl_fetch, mdl_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs must match the queue head while valid; a handshake retires the head.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid) begin
        if (req_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_req: addr %h issued, no fetch expected", imem_req_addr);
        end else begin
          chk("req_addr", imem_req_addr, req_q[0]);
          if (imem_req_ready) void'(req_q.pop_front());
        end
      end
      if (inst_valid) begin
        if (inst_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_inst: inst %h pc %h presented, none expected", inst, pc);
        end else begin
          chk("inst", inst, inst_q[0]);
          chk("inst_pc", pc, ipc_q[0]);
          if (inst_ready) begin
            void'(inst_q.pop_front());
            void'(ipc_q.pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = 32'd0;
    inst_ready = 1'b0; npc_valid = 1'b0; dnpc = 32'd0;
    req_q.delete(); inst_q.delete(); ipc_q.delete();
    tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_wait", perf_wait_cnt, 32'd0);
    mdl_pc = RST_PC; mdl_fetch = 0; mdl_wait = 0;
    req_q.push_back(RST_PC);
  endtask

  // One full instruction: request, response after wd idle WAIT cycles, decode accept, next PC.
  task automatic do_inst(input logic [31:0] nxt, input int rlo, input int wd, input int hlo,
                         input int elo, input bit stray);
    int n;
    logic [31:0] d;
    n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    if (!imem_req_valid) begin chk("req_wait_bound", 32'(imem_req_valid), 32'd1); return; end
    repeat (rlo) begin imem_rsp_valid = stray; imem_rsp_data = $urandom; tick(); end
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (wd) tick();
    d = $urandom;
    inst_q.push_back(d); ipc_q.push_back(mdl_pc);
    imem_rsp_valid = 1'b1; imem_rsp_data = d;
    tick();
    imem_rsp_valid = 1'b0;
    mdl_wait += wd + 1;
    n = 0;
    while (!inst_valid && n < 20) begin tick(); n++; end
    if (!inst_valid) begin chk("inst_wait_bound", 32'(inst_valid), 32'd1); return; end
    repeat (hlo) begin
      npc_valid = stray; dnpc = $urandom; imem_rsp_valid = stray; imem_rsp_data = $urandom;
      tick();
    end
    npc_valid = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    mdl_fetch++;
    repeat (elo) begin inst_ready = stray; imem_rsp_valid = stray; tick(); end
    inst_ready = 1'b0; imem_rsp_valid = 1'b0;
    if (nxt[1:0] == 2'b00) req_q.push_back(nxt);
    npc_valid = 1'b1; dnpc = nxt;
    tick();
    npc_valid = 1'b0;
    if (nxt[1:0] == 2'b00) mdl_pc = nxt;
  endtask

  initial begin
    int hits;
    logic [31:0] lpc, r;
    do_reset();

    // Zero-wait memory, everything tied ready: an instruction every 4 cycles.
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    inst_ready = 1'b1; npc_valid = 1'b1;
    hits = 0; lpc = RST_PC;
    for (int i = 0; i < 12; i++) begin
      if (inst_valid) begin
        hits++;
        chk("lat_phase", 32'(i % 4), 32'd2);
        inst_q.push_back(32'h0000_0013); ipc_q.push_back(lpc);
        dnpc = lpc + 32'd4;
        lpc  = lpc + 32'd4;
        req_q.push_back(lpc);
      end
      tick();
    end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0; npc_valid = 1'b0;
    chk("lat_pulses", 32'(hits), 32'd3);

    // Randomized run with back-pressure, stray inputs, jumps and PC wrap.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        r = mdl_pc + 32'd4;
      end else if (r < 9) begin
        r = $urandom;
        r[1:0] = 2'b00;
      end else begin
        r = 32'hFFFF_FFFC;
      end
      do_inst(r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
`ifdef YSYX_23060201_IFU_PERF_EN
    chk("rand_perf_fetch", perf_fetch_cnt, mdl_fetch);
    chk("rand_perf_wait", perf_wait_cnt, mdl_wait);
`else
    chk("rand_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rand_perf_wait", perf_wait_cnt, 32'd0);
`endif

    // Jump, then misaligned dnpc.
    do_inst(32'h8000_0100, 0, 0, 0, 0, 1'b0);
    do_inst(32'h8000_0102, 0, 0, 0, 0, 1'b0);
    chk("misalign_err_lag", 32'(fetch_err), 32'd0);
    tick();
    chk("misalign_err", 32'(fetch_err), 32'd1);
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; inst_ready = 1'b1;
    repeat (6) tick();
    chk("misalign_no_req", 32'(imem_req_valid), 32'd0);
    chk("misalign_pc", pc, 32'h8000_0100);
    chk("misalign_err_sticky", 32'(fetch_err), 32'd1);

    // Bus error on the response.
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    chk("buserr_err_lag", 32'(fetch_err), 32'd0);
    tick();
    chk("buserr_err", 32'(fetch_err), 32'd1);
    repeat (3) tick();
    do_reset();
    do_inst(RST_PC + 32'd4, 0, 0, 0, 0, 1'b0);

    // Timeout: no response after acceptance.
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("timeout_err", 32'(fetch_err), (k == 5) ? 32'd1 : 32'd0);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_0013;
    repeat (3) tick();
    imem_rsp_valid = 1'b0;
    chk("timeout_late_rsp", 32'(fetch_err), 32'd1);

    // Reset mid-WAIT, stray response in the first REQ cycle, then perf counts.
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    do_reset();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("stray_rsp_req_valid", 32'(imem_req_valid), 32'd1);
    chk("stray_rsp_inst", inst, 32'd0);
    for (int i = 0; i < 3; i++) do_inst(mdl_pc + 32'd4, 0, 1, 0, 0, 1'b0);
`ifdef YSYX_23060201_IFU_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd3);
    chk("perf_wait", perf_wait_cnt, 32'd6);
`else
    chk("perf_fetch", perf_fetch_cnt, 32'd0);
    chk("perf_wait", perf_wait_cnt, 32'd0);
`endif
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
